// File: rtl/poisson_encode_scheduler.sv
// poisson_encode_scheduler: time-multiplexes one LFSR Poisson rate encoder over a frame of pixels for a window of timesteps
//   clk, rst                   clock and synchronous active-high reset
//   start                      begin a frame (sampled only when idle)
//   pixel_rd_en, pixel_addr    synchronous pixel buffer read port
//   pixel_data                 read data, valid the cycle after pixel_rd_en
//   spike_valid/spike_ready    spike stream handshake
//   spike, spike_pixel, spike_step  spike bit and its pixel and timestep
//   busy, done                 frame in progress / one-cycle end-of-frame pulse
module poisson_encode_scheduler #(
  parameter int WIDTH = 16,
  parameter int NUM_PIXELS = 16,
  parameter int WINDOW_SIZE = 5,
  parameter logic [15:0] SEED = 16'h005A,
  localparam int PW = $clog2(NUM_PIXELS),
  localparam int SW = $clog2(WINDOW_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             pixel_rd_en,
  output logic [PW-1:0]    pixel_addr,
  input  logic [WIDTH-1:0] pixel_data,
  output logic             spike_valid,
  input  logic             spike_ready,
  output logic             spike,
  output logic [PW-1:0]    spike_pixel,
  output logic [SW-1:0]    spike_step,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;
  state_t state;
  logic [15:0] lfsr;
  logic [15:0] cand;
  logic [PW-1:0] pix;
  logic [SW-1:0] step;
  assign cand = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[7]};
  assign pixel_rd_en = state == FETCH;
  assign pixel_addr = pix;
  assign spike_valid = state == EMIT;
  assign busy = state == FETCH || state == WAIT || state == EMIT;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr <= SEED;
      pix <= '0;
      step <= '0;
      spike <= 1'b0;
      spike_pixel <= '0;
      spike_step <= '0;
    end else begin
      case (state)
        IDLE: state <= start ? FETCH : IDLE;
        FETCH: state <= WAIT;
        WAIT: begin
          spike <= cand < pixel_data;
          lfsr <= cand;
          spike_pixel <= pix;
          spike_step <= step;
          state <= EMIT;
        end
        EMIT: if (spike_ready) begin
          state <= FETCH;
          if (pix == PW'(NUM_PIXELS - 1)) begin
            pix <= '0;
            if (step == SW'(WINDOW_SIZE - 1)) begin
              step <= '0;
              state <= DONE;
            end else step <= step + 1'b1;
          end else pix <= pix + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poisson_encode_scheduler.sv
// tb_poisson_encode_scheduler: directed scoreboard bench for poisson_encode_scheduler
module tb_poisson_encode_scheduler;
  localparam int N = 2;
  localparam int W = 2;
  localparam int PW = $clog2(N);
  localparam int SW = $clog2(W);
  localparam logic [15:0] SEED = 16'h005A;
  logic clk = 0, rst = 0, start = 0, spike_ready = 1;
  logic pixel_rd_en, spike_valid, spike, busy, done;
  logic [PW-1:0] pixel_addr, spike_pixel;
  logic [SW-1:0] spike_step;
  logic [15:0] pixel_data = '0;
  logic [15:0] mem [N];
  logic [15:0] lfsr_m;
  typedef struct {logic s; int p; int st;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int dc;
  logic fs;
  poisson_encode_scheduler #(.WIDTH(16), .NUM_PIXELS(N), .WINDOW_SIZE(W), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .pixel_rd_en(pixel_rd_en), .pixel_addr(pixel_addr),
    .pixel_data(pixel_data), .spike_valid(spike_valid), .spike_ready(spike_ready), .spike(spike),
    .spike_pixel(spike_pixel), .spike_step(spike_step), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (pixel_rd_en) pixel_data <= mem[pixel_addr];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[7]};
  endfunction
  task automatic push_frame;
    for (int s = 0; s < W; s++)
      for (int p = 0; p < N; p++) begin
        lfsr_m = nxt(lfsr_m);
        q.push_back('{lfsr_m < mem[p], p, s});
      end
  endtask
  task automatic do_reset;
    rst = 1;
    start = 0;
    spike_ready = 1;
    tick();
    tick();
    rst = 0;
    lfsr_m = SEED;
    q.delete();
  endtask
  task automatic run_frame(input int stall, input bit poke, output int done_cyc, output logic first_spk);
    int k, left;
    bit seen;
    logic [31:0] snap;
    exp_t e;
    done_cyc = -1;
    first_spk = 1'bx;
    left = stall;
    seen = 0;
    snap = '0;
    push_frame();
    spike_ready = 1;
    start = 1;
    tick();
    start = 0;
    k = 1;
    check("rd_en_cycle1", {pixel_rd_en, 31'(pixel_addr)}, {1'b1, 31'd0});
    while (k < 400) begin
      spike_ready = 1;
      if (spike_valid) begin
        if (!seen) begin
          seen = 1;
          check("first_valid_cycle", k, 3);
          first_spk = spike;
          snap = {spike, 15'(spike_pixel), 16'(spike_step)};
        end
        if (left > 0) begin
          if (left < stall) check("stall_stable", {spike, 15'(spike_pixel), 16'(spike_step)}, snap);
          left--;
          spike_ready = 0;
        end else if (q.size() == 0) check("extra_transfer", 1, 0);
        else begin
          e = q.pop_front();
          check($sformatf("spike_p%0d_s%0d", e.p, e.st), spike, e.s);
          check("spike_pixel", spike_pixel, e.p);
          check("spike_step", spike_step, e.st);
        end
      end
      if (done) begin
        done_cyc = k;
        break;
      end
      start = poke && k == 5;
      tick();
      k++;
    end
    if (done_cyc < 0) check("frame_timeout", 0, 1);
    check("transfers_remaining", q.size(), 0);
    start = poke;
    tick();
    start = 0;
    check("after_done", {done, busy, spike_valid}, 3'b000);
    tick();
    check("idle_no_restart", {pixel_rd_en, busy}, 2'b00);
  endtask
  initial begin
    int guard;
    bit saw;
    mem[0] = 16'h00B5;
    mem[1] = 16'h00B5;
    do_reset();
    check("reset_outputs", {pixel_rd_en, 15'(pixel_addr), spike_valid, spike, 7'(spike_pixel), 4'(spike_step), busy, done}, '0);
    // basic frame: first spike is 1 since cand 00B4 < 00B5
    run_frame(0, 0, dc, fs);
    check("t1_done_cycle", dc, 13);
    check("t1_first_spike", fs, 1);
    // strict compare then an all-zero frame
    do_reset();
    mem[0] = 16'h00B4;
    run_frame(0, 0, dc, fs);
    check("t2_strict_first", fs, 0);
    mem[0] = 16'h0000;
    mem[1] = 16'h0000;
    run_frame(0, 0, dc, fs);
    check("t2_zero_first", fs, 0);
    // backpressure in the first EMIT
    do_reset();
    mem[0] = 16'h00B5;
    mem[1] = 16'h00B5;
    run_frame(5, 0, dc, fs);
    check("t3_done_delayed", dc, 18);
    check("t3_first_spike", fs, 1);
    // start pulses while busy and in DONE are ignored
    mem[0] = 16'hFFFF;
    mem[1] = 16'h8000;
    run_frame(0, 1, dc, fs);
    check("t4_done_cycle", dc, 13);
    // back-to-back frames keep the LFSR running
    mem[0] = 16'h1234;
    mem[1] = 16'hC000;
    run_frame(0, 0, dc, fs);
    run_frame(0, 0, dc, fs);
    check("t6_done_cycle", dc, 13);
    // reset mid-frame, then restart matches the first frame
    do_reset();
    mem[0] = 16'h00B5;
    mem[1] = 16'h00B5;
    push_frame();
    start = 1;
    tick();
    start = 0;
    guard = 0;
    while (!(spike_valid && spike_step == 1) && guard < 100) begin
      tick();
      guard++;
    end
    check("t5_reached_step1", {spike_valid, 31'(spike_step)}, {1'b1, 31'd1});
    rst = 1;
    tick();
    rst = 0;
    check("t5_reset_outputs", {pixel_rd_en, 15'(pixel_addr), spike_valid, spike, 7'(spike_pixel), 4'(spike_step), busy, done}, '0);
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      saw |= done | busy;
      tick();
    end
    check("t5_no_done", saw, 0);
    lfsr_m = SEED;
    q.delete();
    run_frame(0, 0, dc, fs);
    check("t5_done_cycle", dc, 13);
    check("t5_first_spike", fs, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
